// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, quarter-wave sine fold, arithmetic square/triangle/sawtooth.
// Optional midscale amplitude shift stage when DDS_AMP_SCALE_EN is defined (adds amp_shift, latency 4).
module dds_wave_gen #(
  parameter logic [31:0] FREQ_WORD  = 32'd85899,
  parameter logic [11:0] PHASE_CTRL = 12'd1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  wave_select,
  input  logic [31:0] freq_word,
  input  logic        freq_load,
`ifdef DDS_AMP_SCALE_EN
  input  logic [1:0]  amp_shift,
`endif
  output logic [9:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  dout,
  output logic        dout_valid
);

  localparam logic [3:0] WAVE_SINE = 4'b0001;
  localparam logic [3:0] WAVE_SQR  = 4'b0010;
  localparam logic [3:0] WAVE_TRI  = 4'b0100;
  localparam logic [3:0] WAVE_SAW  = 4'b1000;

  function automatic logic [7:0] wave_value(input logic [3:0] wave, input logic [11:0] addr);
    logic [7:0] v;
    case (wave)
      WAVE_SQR: v = addr[11] ? 8'h00 : 8'hFF;
      WAVE_TRI: v = addr[11] ? ~addr[10:3] : addr[10:3];
      WAVE_SAW: v = addr[11:4];
      default:  v = 8'h80;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] sine_unfold(input logic lower_half, input logic [7:0] d);
    return lower_half ? (8'd255 - d) : d;
  endfunction

`ifdef DDS_AMP_SCALE_EN
  // Arithmetic shift of the sample about midscale; MSB flip converts offset-binary <-> two's complement.
  function automatic logic [7:0] amp_scale(input logic [7:0] s, input logic [1:0] sh);
    logic signed [7:0] d;
    d = $signed(s ^ 8'h80);
    d = d >>> sh;
    return $unsigned(d) ^ 8'h80;
  endfunction
`endif

  logic [31:0] freq_reg;
  logic [31:0] phase_acc_p0;
  logic [3:0]  wave_reg;
  logic        wave_legal;
  logic        wave_chg;
  logic [11:0] addr_p0;

  assign wave_legal = ((wave_select & (wave_select - 4'd1)) == 4'd0);
  assign wave_chg   = wave_legal && (wave_select != wave_reg);
  assign addr_p0    = phase_acc_p0[31:20] + PHASE_CTRL;

  // Stage 0: frequency word, wave register, phase accumulator
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      freq_reg     <= FREQ_WORD;
      wave_reg     <= 4'b0000;
      phase_acc_p0 <= 32'd0;
    end else begin
      if (freq_load)
        freq_reg <= freq_word;
      if (wave_chg) begin
        wave_reg     <= wave_select;
        phase_acc_p0 <= 32'd0;
      end else begin
        phase_acc_p0 <= phase_acc_p0 + freq_reg;
      end
    end
  end

  logic       q1_p1;
  logic [3:0] wave_p1;
  logic [7:0] nsv_p1;
  logic       vld_p1;

  // Stage 1: table address, quarter fold to ROM address, non-sine sample
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rom_addr <= 10'd0;
      q1_p1    <= 1'b0;
      wave_p1  <= 4'b0000;
      nsv_p1   <= 8'h80;
      vld_p1   <= 1'b0;
    end else begin
      rom_addr <= addr_p0[10] ? ~addr_p0[9:0] : addr_p0[9:0];
      q1_p1    <= addr_p0[11];
      wave_p1  <= wave_reg;
      nsv_p1   <= wave_value(wave_reg, addr_p0);
      vld_p1   <= ~wave_chg;
    end
  end

  logic       q1_p2;
  logic [3:0] wave_p2;
  logic [7:0] nsv_p2;
  logic       vld_p2;

  // Stage 2: ROM access cycle, side information delayed alongside
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      q1_p2   <= 1'b0;
      wave_p2 <= 4'b0000;
      nsv_p2  <= 8'h80;
      vld_p2  <= 1'b0;
    end else begin
      q1_p2   <= q1_p1;
      wave_p2 <= wave_p1;
      nsv_p2  <= nsv_p1;
      vld_p2  <= vld_p1 & ~wave_chg;
    end
  end

  logic [7:0] samp_p2;
  assign samp_p2 = (wave_p2 == WAVE_SINE) ? sine_unfold(q1_p2, rom_data) : nsv_p2;

`ifdef DDS_AMP_SCALE_EN
  logic [7:0] samp_p3;
  logic [1:0] amp_p3;
  logic       vld_p3;

  // Stage 3: sample select, amplitude shift sampled
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      samp_p3 <= 8'h80;
      amp_p3  <= 2'd0;
      vld_p3  <= 1'b0;
    end else begin
      samp_p3 <= samp_p2;
      amp_p3  <= amp_shift;
      vld_p3  <= vld_p2 & ~wave_chg;
    end
  end

  // Stage 4: scaled output register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dout       <= 8'h80;
      dout_valid <= 1'b0;
    end else begin
      dout       <= amp_scale(samp_p3, amp_p3);
      dout_valid <= vld_p3 & ~wave_chg;
    end
  end
`else
  // Stage 3: output register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dout       <= 8'h80;
      dout_valid <= 1'b0;
    end else begin
      dout       <= samp_p2;
      dout_valid <= vld_p2 & ~wave_chg;
    end
  end
`endif

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: two instances (PHASE_CTRL 0 and default 1024) with 1-cycle ROM models.
module tb_dds_wave_gen;

  logic        sys_clk;
  logic        sys_rst;
  logic [3:0]  wave_select;
  logic [31:0] freq_word;
  logic        freq_load;
  logic [9:0]  rom_addr, rom_addr_p;
  logic [7:0]  rom_data, rom_data_p;
  logic [7:0]  dout, dout_p;
  logic        dout_valid, dout_valid_p;

  logic [7:0]  rom_tbl [0:1023];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  dds_wave_gen #(.PHASE_CTRL(12'd0)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wave_select(wave_select),
    .freq_word(freq_word), .freq_load(freq_load), .rom_addr(rom_addr),
    .rom_data(rom_data), .dout(dout), .dout_valid(dout_valid)
  );

  dds_wave_gen dut_p (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wave_select(wave_select),
    .freq_word(freq_word), .freq_load(freq_load), .rom_addr(rom_addr_p),
    .rom_data(rom_data_p), .dout(dout_p), .dout_valid(dout_valid_p)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    for (int k = 0; k < 1024; k++)
      rom_tbl[k] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 4096.0) + 0.5));
  end

  always @(posedge sys_clk) begin
    rom_data   <= rom_tbl[rom_addr];
    rom_data_p <= rom_tbl[rom_addr_p];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic switch_wave(input logic [3:0] w);
    wave_select = w;
    cyc = -1;
    tick();
    freq_load = 1'b0;
  endtask

  task automatic do_reset();
    wave_select = 4'b0000;
    freq_load   = 1'b0;
    sys_rst     = 1'b1;
    #2;
    chk("rst_dout", dout, 8'h80);
    chk("rst_valid", dout_valid, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_addr_p", rom_addr_p, 0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    cyc = 0;
    run_to(1); chk("rel_vld1", dout_valid, 0);
    run_to(2); chk("rel_vld2", dout_valid, 0);
    run_to(3); chk("rel_vld3", dout_valid, 1); chk("rel_off", dout, 8'h80);
    run_to(13); chk("fw_addr13", rom_addr, 0); chk("fw_addr13_p", rom_addr_p, 10'd1023);
    run_to(14); chk("fw_addr14", rom_addr, 1); chk("fw_addr14_p", rom_addr_p, 10'd1022);
    chk("off_dout", dout, 8'h80); chk("off_valid", dout_valid, 1);
  endtask

  initial begin
    sys_rst     = 1'b0;
    wave_select = 4'b0000;
    freq_word   = 32'd0;
    freq_load   = 1'b0;
    #1;
    do_reset();

    // square, with the new step loaded on the same edge as the wave change
    freq_word = 32'h0010_0000;
    freq_load = 1'b1;
    switch_wave(4'b0010);
    chk("sq_vld0", dout_valid, 0);
    run_to(2); chk("sq_vld2", dout_valid, 0);
    run_to(3); chk("sq_vld3", dout_valid, 1); chk("sq_first", dout, 8'hFF); chk("sq_first_p", dout_p, 8'hFF);
    run_to(1026); chk("sq_p_hi", dout_p, 8'hFF);
    run_to(1027); chk("sq_p_lo", dout_p, 8'h00);
    run_to(2050); chk("sq_hi_end", dout, 8'hFF);
    run_to(2051); chk("sq_lo_start", dout, 8'h00);
    run_to(4098); chk("sq_lo_end", dout, 8'h00);
    run_to(4099); chk("sq_period", dout, 8'hFF);

    // sine
    switch_wave(4'b0001);
    chk("sin_vld0", dout_valid, 0);
    run_to(1); chk("sin_addr0", rom_addr, 0); chk("sin_addr0_p", rom_addr_p, 10'd1023);
    run_to(3); chk("sin_vld3", dout_valid, 1); chk("sin_first", dout, rom_tbl[0]);
    chk("sin_first_p", dout_p, rom_tbl[1023]);
    run_to(259); chk("sin_q0", dout, rom_tbl[256]);
    run_to(1024); chk("sin_addr1023", rom_addr, 10'd1023);
    run_to(1025); chk("sin_addr_dup", rom_addr, 10'd1023);
    run_to(2048); chk("sin_addr_q1end", rom_addr, 0);
    run_to(2049); chk("sin_addr_q2", rom_addr, 0);
    run_to(2151); chk("sin_q2", dout, 8'd255 - rom_tbl[100]);
    run_to(3079);
    wave_select = 4'b0011;
    tick();
    chk("ill_vld", dout_valid, 1); chk("ill_q3", dout, 8'd255 - rom_tbl[1018]);
    wave_select = 4'b0001;
    tick();
    chk("ill_cont", dout, 8'd255 - rom_tbl[1017]);

    // triangle
    switch_wave(4'b0100);
    chk("tri_vld0", dout_valid, 0);
    run_to(1); chk("tri_vld1", dout_valid, 0);
    run_to(2); chk("tri_vld2", dout_valid, 0);
    run_to(3); chk("tri_vld3", dout_valid, 1); chk("tri_first", dout, 8'h00); chk("tri_first_p", dout_p, 8'h80);
    run_to(10); chk("tri_hold", dout, 8'h00);
    run_to(11); chk("tri_step", dout, 8'h01);
    run_to(2050); chk("tri_peak", dout, 8'hFF);
    run_to(2051); chk("tri_peak2", dout, 8'hFF);
    run_to(2059); chk("tri_down", dout, 8'hFE);

    // sawtooth
    switch_wave(4'b1000);
    chk("saw_vld0", dout_valid, 0);
    run_to(1); chk("saw_vld1", dout_valid, 0);
    run_to(2); chk("saw_vld2", dout_valid, 0);
    run_to(3); chk("saw_vld3", dout_valid, 1); chk("saw_first", dout, 8'h00);
    run_to(18); chk("saw_hold", dout, 8'h00);
    run_to(19); chk("saw_step", dout, 8'h01);
    run_to(4098); chk("saw_top", dout, 8'hFF);
    run_to(4099); chk("saw_wrap", dout, 8'h00);

    // async reset mid-stream; frequency word must return to its reset value
    chk("pre_rst_vld", dout_valid, 1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
